// File: rtl/dg_tribus_pkg.sv
// Shared types and helpers for the tri-state bus driver: FSM state encoding,
// width helper and request population count.
package dg_tribus_pkg;

    localparam int MAX_CHANNELS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Smallest n with (1 << n) >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int onehot_count(input logic [MAX_CHANNELS-1:0] vec);
        int total;
        total = 0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (vec[i]) begin
                total++;
            end
        end
        return total;
    endfunction

endpackage

// File: rtl/dg_rr_arbiter.sv
// Combinational round-robin pick: the first requester found when searching
// upward (with wrap) from the channel after the previous owner.
module dg_rr_arbiter
    import dg_tribus_pkg::*;
#(
    parameter  int CHANNELS = 3,
    localparam int IDXW     = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDXW-1:0]     last_owner,
    output logic [CHANNELS-1:0] grant_next,
    output logic [IDXW-1:0]     index
);

    logic            found;
    logic [IDXW-1:0] cand;

    always_comb begin
        grant_next = '0;
        index      = '0;
        found      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = IDXW'((int'(last_owner) + k) % CHANNELS);
            if (!found && req[cand]) begin
                found            = 1'b1;
                grant_next[cand] = 1'b1;
                index            = cand;
            end
        end
    end

endmodule

// File: rtl/dg_tribus_driver.sv
// Multi-channel tri-state bus driver: round-robin ownership, registered
// enables, break-before-make turnaround and optional bus keeper.
module dg_tribus_driver
    import dg_tribus_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int CHANNELS    = 3,
    parameter int TURN_CYCLES = 1,
    parameter int KEEPER      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output tri   [WIDTH-1:0]          y,
    output logic                      oe,
    output logic [CHANNELS-1:0]       grant,
    output logic                      busy,
    output logic                      contention
);

    localparam int IDXW = clog2(CHANNELS);
    localparam int CNTW = (clog2(TURN_CYCLES + 1) < 1) ? 1 : clog2(TURN_CYCLES + 1);

    if (TURN_CYCLES < 1) begin : g_bad_turn
        $error("dg_tribus_driver: TURN_CYCLES must be at least 1");
    end
    if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("dg_tribus_driver: CHANNELS out of range");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("dg_tribus_driver: WIDTH must be at least 1");
    end

    state_t                state, state_next;
    logic [CNTW-1:0]       cnt, cnt_next;
    logic [IDXW-1:0]       last_owner, last_next;
    logic [IDXW-1:0]       owner, owner_next;
    logic [CHANNELS-1:0]   grant_next;
    logic                  oe_next;
    logic                  contention_next;
    logic [CHANNELS-1:0]   req_clean;
    logic [CHANNELS-1:0]   arb_grant;
    logic [IDXW-1:0]       arb_index;
    logic [WIDTH-1:0]      chan_data [CHANNELS];
    logic [WIDTH-1:0]      owner_data;

    // Unknown request bits fall into the else branch and count as idle.
    always_comb begin
        req_clean = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (req[i]) begin
                req_clean[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign chan_data[i] = d[i*WIDTH +: WIDTH];
    end

    assign owner_data = chan_data[owner];

    dg_rr_arbiter #(
        .CHANNELS(CHANNELS)
    ) u_arbiter (
        .req       (req_clean),
        .last_owner(last_owner),
        .grant_next(arb_grant),
        .index     (arb_index)
    );

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        last_next       = last_owner;
        owner_next      = owner;
        grant_next      = grant;
        oe_next         = oe;
        contention_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_clean) begin
                    grant_next      = arb_grant;
                    owner_next      = arb_index;
                    oe_next         = 1'b1;
                    contention_next = (onehot_count(MAX_CHANNELS'(req_clean)) > 1);
                    state_next      = DRIVE;
                end
            end
            DRIVE: begin
                if (!req_clean[owner]) begin
                    grant_next = '0;
                    oe_next    = 1'b0;
                    last_next  = owner;
                    cnt_next   = CNTW'(TURN_CYCLES);
                    state_next = TURN;
                end
            end
            TURN: begin
                // The IDLE cycle that follows supplies the extra gap cycle.
                if (cnt <= CNTW'(1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNTW'(1);
                end
            end
            default: begin
                grant_next = '0;
                oe_next    = 1'b0;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= IDXW'(CHANNELS - 1);
            owner      <= '0;
            grant      <= '0;
            oe         <= 1'b0;
            contention <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_owner <= last_next;
            owner      <= owner_next;
            grant      <= grant_next;
            oe         <= oe_next;
            contention <= contention_next;
        end
    end

    assign busy = (state != IDLE);

    if (KEEPER != 0) begin : g_keeper
        logic [WIDTH-1:0] keep;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                keep <= '0;
            end else if (oe) begin
                keep <= owner_data;
            end
        end

        assign y = oe ? owner_data : keep;
    end else begin : g_float
        assign y = oe ? owner_data : {WIDTH{1'bz}};
    end

endmodule

// File: tb/tb_dg_tribus_driver.sv
// Self-checking bench for dg_tribus_driver: a directed vector table on a
// 3-channel float bus, keeper/turnaround sequences, async reset and a random run.
module tb_dg_tribus_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut_a: WIDTH=1, CHANNELS=3, TURN_CYCLES=1, floating bus
    logic [2:0] req_a = '0;
    logic [2:0] d_a   = '0;
    wire  [0:0] y_a;
    logic       oe_a, busy_a, cont_a;
    logic [2:0] grant_a;

    // dut_b: WIDTH=8, CHANNELS=3, TURN_CYCLES=3, keeper
    logic [2:0]  req_b = '0;
    logic [23:0] d_b   = '0;
    wire  [7:0]  y_b;
    logic        oe_b, busy_b, cont_b;
    logic [2:0]  grant_b;

    // dut_c: WIDTH=4, CHANNELS=5, TURN_CYCLES=2, floating bus
    logic [4:0]  req_c = '0;
    logic [19:0] d_c   = '0;
    wire  [3:0]  y_c;
    logic        oe_c, busy_c, cont_c;
    logic [4:0]  grant_c;

    dg_tribus_driver #(.WIDTH(1), .CHANNELS(3), .TURN_CYCLES(1), .KEEPER(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .d(d_a), .y(y_a), .oe(oe_a),
        .grant(grant_a), .busy(busy_a), .contention(cont_a)
    );

    dg_tribus_driver #(.WIDTH(8), .CHANNELS(3), .TURN_CYCLES(3), .KEEPER(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .d(d_b), .y(y_b), .oe(oe_b),
        .grant(grant_b), .busy(busy_b), .contention(cont_b)
    );

    dg_tribus_driver #(.WIDTH(4), .CHANNELS(5), .TURN_CYCLES(2), .KEEPER(0)) dut_c (
        .clk(clk), .rst(rst), .req(req_c), .d(d_c), .y(y_c), .oe(oe_c),
        .grant(grant_c), .busy(busy_c), .contention(cont_c)
    );

    typedef struct {
        logic [2:0] req;
        logic [2:0] d;
        logic [2:0] grant;
        logic       oe;
        logic       busy;
        logic       cont;
        logic       y;
    } vec_t;

    vec_t vecs [17];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one table row between edges, then look at the state it produced.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        req_a = v.req;
        d_a   = v.d;
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random run on dut_c
    int         m_state, m_cnt, m_last, m_owner, cidx, low_run;
    logic [4:0] m_grant;
    logic       m_cont, prev_oe, seen_release;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 3'b001, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{3'b001, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b111, 3'b010, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{3'b111, 3'b000, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'b101, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b101, 3'b100, 3'b100, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b001, 3'b001, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'b011, 3'b001, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{3'b010, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'b010, 3'b000, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("rst_grant_a", 32'(grant_a), 32'd0);
        check_output("rst_oe_a", 32'(oe_a), 32'd0);
        check_output("rst_busy_a", 32'(busy_a), 32'd0);
        check_output("rst_cont_a", 32'(cont_a), 32'd0);
        check_output("rst_oe_b", 32'(oe_b), 32'd0);
        check_output("rst_keep_b", 32'(y_b), 32'h00);

        // Directed table: first grant, passthrough, turnaround, rotation, contention
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_grant", i), 32'(grant_a), 32'(vecs[i].grant));
            check_output($sformatf("vec%0d_oe", i), 32'(oe_a), 32'(vecs[i].oe));
            check_output($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].busy));
            check_output($sformatf("vec%0d_cont", i), 32'(cont_a), 32'(vecs[i].cont));
            if (vecs[i].oe) begin
                check_output($sformatf("vec%0d_y", i), 32'(y_a), 32'(vecs[i].y));
            end
        end

        // Keeper bus: hold A5 through a 3-cycle turnaround, then hand over to channel 1
        @(negedge clk);
        req_a = '0;
        req_b = 3'b011;
        d_b   = {8'h00, 8'h3C, 8'hA5};
        @(posedge clk);
        #1;
        check_output("kb_grant0", 32'(grant_b), 32'b001);
        check_output("kb_cont0", 32'(cont_b), 32'd1);
        check_output("kb_y_a5", 32'(y_b), 32'hA5);
        @(negedge clk);
        d_b[7:0] = 8'h5A;
        #1;
        check_output("kb_passthru", 32'(y_b), 32'h5A);
        d_b[7:0] = 8'hA5;
        #1;
        check_output("kb_passback", 32'(y_b), 32'hA5);
        @(negedge clk);
        req_b = 3'b010;
        @(posedge clk);
        #1;
        check_output("kb_rel_oe", 32'(oe_b), 32'd0);
        check_output("kb_rel_grant", 32'(grant_b), 32'd0);
        check_output("kb_rel_busy", 32'(busy_b), 32'd1);
        check_output("kb_rel_y", 32'(y_b), 32'hA5);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("kb_turn%0d_oe", k), 32'(oe_b), 32'd0);
            check_output($sformatf("kb_turn%0d_y", k), 32'(y_b), 32'hA5);
        end
        @(posedge clk);
        #1;
        check_output("kb_grant1", 32'(grant_b), 32'b010);
        check_output("kb_cont1", 32'(cont_b), 32'd0);
        check_output("kb_y_3c", 32'(y_b), 32'h3C);
        @(negedge clk);
        req_b = '0;
        @(posedge clk);
        #1;
        check_output("kb_keep_3c", 32'(y_b), 32'h3C);

        // Async reset in the middle of a DRIVE cycle
        @(negedge clk);
        req_a = 3'b001;
        d_a   = 3'b001;
        @(posedge clk);
        #1;
        check_output("ar_pre_grant", 32'(grant_a), 32'b001);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("ar_grant", 32'(grant_a), 32'd0);
        check_output("ar_oe", 32'(oe_a), 32'd0);
        check_output("ar_busy", 32'(busy_a), 32'd0);
        check_output("ar_keep_b", 32'(y_b), 32'h00);
        rst   = 1'b0;
        req_a = 3'b111;
        @(posedge clk);
        #1;
        check_output("ar_first_grant", 32'(grant_a), 32'b001);
        check_output("ar_first_cont", 32'(cont_a), 32'd1);

        // A request pulse entirely between edges must go unseen
        @(negedge clk);
        req_a = '0;
        #1;
        req_c = 5'b00100;
        #2;
        req_c = '0;
        @(posedge clk);
        #1;
        check_output("pulse_grant", 32'(grant_c), 32'd0);
        check_output("pulse_busy", 32'(busy_c), 32'd0);

        // Random run on dut_c against a behavioural model
        m_state = 0; m_cnt = 0; m_last = 4; m_owner = 0;
        m_grant = '0; m_cont = 1'b0;
        prev_oe = 1'b0; seen_release = 1'b0; low_run = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            req_c = 5'($urandom);
            d_c   = 20'($urandom);
            @(posedge clk);
            m_cont = 1'b0;
            if (m_state == 0) begin
                if (req_c != 0) begin
                    for (int k = 1; k <= 5; k++) begin
                        cidx = (m_last + k) % 5;
                        if (req_c[cidx]) begin
                            m_owner = cidx;
                            break;
                        end
                    end
                    m_grant = 5'(1 << m_owner);
                    m_cont  = ($countones(req_c) > 1);
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (!req_c[m_owner]) begin
                    m_grant = '0;
                    m_last  = m_owner;
                    m_cnt   = 2;
                    m_state = 2;
                end
            end else begin
                if (m_cnt == 1) m_state = 0;
                m_cnt = m_cnt - 1;
            end
            #1;
            check_output("rnd_grant", 32'(grant_c), 32'(m_grant));
            check_output("rnd_onehot", 32'($onehot0(grant_c)), 32'd1);
            check_output("rnd_oe", 32'(oe_c), 32'(m_grant != 0));
            check_output("rnd_busy", 32'(busy_c), 32'(m_state != 0));
            check_output("rnd_cont", 32'(cont_c), 32'(m_cont));
            if (m_grant != 0) begin
                check_output("rnd_y", 32'(y_c), 32'(d_c[m_owner*4 +: 4]));
            end
            if (oe_c && !prev_oe && seen_release) begin
                check_output("rnd_gap", 32'(low_run >= 3), 32'd1);
            end
            if (!oe_c && prev_oe) seen_release = 1'b1;
            low_run = oe_c ? 0 : low_run + 1;
            prev_oe = oe_c;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
